// File: rtl/mem_stage_sbuf.sv
// Data-memory stage: DEPTH-entry store buffer draining into a word RAM.
// Define SBUF_FWD_EN to forward fully covered loads from the buffer.
module mem_stage_sbuf #(
    parameter int DEPTH    = 4,
    parameter int DM_WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_signed,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic                     interupt,
    output logic                     stall,
    output logic                     misalign,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int AW = $clog2(DM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0]    e_idx  [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [3:0]       e_be   [DEPTH];
    logic [DEPTH-1:0] e_v;
    logic [PW-1:0]    head, tail;
    logic [31:0]      ram [DM_WORDS];

    logic [AW-1:0]    widx;
    logic [3:0]       be;
    logic [31:0]      lane;
    logic [DEPTH-1:0] hit;
    logic             blocked, go, acc, ld_acc, st_acc, drain;
    logic [31:0]      ld_word, rd_word;
    logic [1:0]       r_off, r_size;
    logic             r_sign;
    logic             unused_addr;

    assign widx = req_addr[AW+1:2];
    assign unused_addr = ^req_addr[31:AW+2];

    always_comb begin
        be   = 4'b1111;
        lane = req_wdata;
        unique case (req_size)
            2'b00: begin
                be   = 4'b0001 << req_addr[1:0];
                lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be   = req_addr[1] ? 4'b1100 : 4'b0011;
                lane = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign misalign = req_valid
        & ((req_size == 2'b01 & req_addr[0])
         | (req_size[1] & (|req_addr[1:0])));

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = e_v[i] && (e_idx[i] == widx) && |(e_be[i] & be);
    end

`ifdef SBUF_FWD_EN
    logic [PW-1:0] yng;
    logic          fwd;

    // Walk oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        yng = head;
        for (int k = 0; k < DEPTH; k++)
            if (hit[head + PW'(k)]) yng = head + PW'(k);
    end

    assign fwd     = (|hit) && ((e_be[yng] & be) == be);
    assign blocked = (|hit) && !fwd;
    assign ld_word = fwd ? e_data[yng] : ram[widx];
`else
    assign blocked = |hit;
    assign ld_word = ram[widx];
`endif

    assign go     = req_valid & ~interupt & ~misalign;
    assign stall  = go & (req_we ? (buf_count == FULL) : blocked);
    assign acc    = go & ~stall;
    assign ld_acc = acc & ~req_we;
    assign st_acc = acc & req_we;
    assign drain  = ~ld_acc & (buf_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            buf_count <= '0;
            e_v       <= '0;
        end else begin
            if (st_acc) begin
                e_v[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (drain) begin
                e_v[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            buf_count <= buf_count + (PW+1)'(st_acc) - (PW+1)'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (st_acc) begin
            e_idx[tail]  <= widx;
            e_data[tail] <= lane;
            e_be[tail]   <= be;
        end
    end

    always_ff @(posedge clk) begin
        if (drain)
            for (int b = 0; b < 4; b++)
                if (e_be[head][b])
                    ram[e_idx[head]][8*b +: 8] <= e_data[head][8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_word  <= '0;
            r_off    <= '0;
            r_size   <= '0;
            r_sign   <= 1'b0;
        end else begin
            rd_valid <= ld_acc;
            if (ld_acc) begin
                rd_word <= ld_word;
                r_off   <= req_addr[1:0];
                r_size  <= req_size;
                r_sign  <= req_signed;
            end
        end
    end

    always_comb begin
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = rd_word[{r_off, 3'b000} +: 8];
        h16 = r_off[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (r_size)
            2'b00:   rd_data = {{24{r_sign & b8[7]}}, b8};
            2'b01:   rd_data = {{16{r_sign & h16[15]}}, h16};
            default: rd_data = rd_word;
        endcase
    end
endmodule
